// File: rtl/aes_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_cipher_iter
//  Purpose  : Iterative AES encryption core, one round per clock.
//             Takes a pre-expanded key schedule and returns one 128-bit
//             ciphertext per accepted start (Nr+1 cycles per block).
//  Option   : CIPHER_KEY_LATCH_EN - when defined, the whole key schedule is
//             captured at start so the caller may change keys while busy.
//             When undefined, round keys are read live from the keys port.
//  Revision : 1.0  initial release
// ============================================================================
module aes_cipher_iter #(
    parameter int Nk = 4                     // key words: 4, 6 or 8
) (
    input  logic                     clks,
    input  logic                     reset,
    input  logic                     start,
    input  logic [0:127]             plainText,
    input  logic [0:128*(Nk+7)-1]    keys,   // Nk+7 == Nr+1 round keys
    output logic                     busy,
    output logic                     done,
    output logic [0:127]             cipherText
);

    localparam int Nr = Nk + 6;
    localparam logic [3:0] LAST_MID_ROUND = 4'(Nr - 1);

    // Only AES-128/192/256 key lengths are meaningful.
    generate
        if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
            $error("aes_cipher_iter: Nk must be 4, 6 or 8");
        end
    endgenerate

    // FIPS-197 forward S-box, indexed by input byte value.
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    // ------------------------------------------------------------------
    // Round transforms. State byte n sits at bits [8n:8n+7]; the state is
    // column-major, so byte (row r, column c) is byte r + 4c.
    // ------------------------------------------------------------------
    function automatic logic [0:127] sub_bytes(input logic [0:127] s);
        logic [0:127] o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
            end
        end
        return o;
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(4*c)     +: 8];
            a1 = s[8*(4*c + 1) +: 8];
            a2 = s[8*(4*c + 2) +: 8];
            a3 = s[8*(4*c + 3) +: 8];
            o[8*(4*c)     +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[8*(4*c + 1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[8*(4*c + 2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[8*(4*c + 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUNDS = 2'd1,
        FINAL  = 2'd2
    } fsm_t;

    fsm_t         fsm_state;
    fsm_t         fsm_next;
    logic         load_block;
    logic         do_round;
    logic         do_final;
    logic [3:0]   round_cnt;
    logic [0:127] aes_state;

    // ------------------------------------------------------------------
    // Round-key source: latched copy or live port
    // ------------------------------------------------------------------
    logic [0:128*(Nr+1)-1] key_src;

`ifdef CIPHER_KEY_LATCH_EN
    logic [0:128*(Nr+1)-1] key_store;

    // Capture the full schedule with the block so keys may move while busy.
    always_ff @(posedge clks) begin
        if (reset) begin
            key_store <= '0;
        end else if (load_block) begin
            key_store <= keys;
        end
    end

    assign key_src = key_store;
`else
    assign key_src = keys;
`endif

    logic [0:127] round_key [0:Nr];

    generate
        for (genvar i = 0; i <= Nr; i++) begin : g_rk
            assign round_key[i] = key_src[128*i +: 128];
        end
    endgenerate

    logic [0:127] sr_out;
    logic [0:127] mid_out;
    logic [0:127] last_out;
    logic [0:127] key_sel;

    assign key_sel  = round_key[round_cnt];
    assign sr_out   = shift_rows(sub_bytes(aes_state));
    assign mid_out  = mix_columns(sr_out) ^ key_sel;
    assign last_out = sr_out ^ key_sel;

    // FSM state register.
    always_ff @(posedge clks) begin
        if (reset) begin
            fsm_state <= IDLE;
        end else begin
            fsm_state <= fsm_next;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        fsm_next   = fsm_state;
        load_block = 1'b0;
        do_round   = 1'b0;
        do_final   = 1'b0;
        case (fsm_state)
            IDLE: begin
                if (start) begin
                    load_block = 1'b1;
                    fsm_next   = ROUNDS;
                end
            end
            ROUNDS: begin
                do_round = 1'b1;
                if (round_cnt == LAST_MID_ROUND) begin
                    fsm_next = FINAL;
                end
            end
            FINAL: begin
                do_final = 1'b1;
                fsm_next = IDLE;
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // Datapath: state, round counter and outputs. Initial whitening uses the
    // live key 0 because any latched copy is only written on this same edge.
    always_ff @(posedge clks) begin
        if (reset) begin
            aes_state  <= '0;
            round_cnt  <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cipherText <= '0;
        end else begin
            done <= 1'b0;
            if (load_block) begin
                aes_state <= plainText ^ keys[0:127];
                round_cnt <= 4'd1;
                busy      <= 1'b1;
            end
            if (do_round) begin
                aes_state <= mid_out;
                round_cnt <= round_cnt + 4'd1;
            end
            if (do_final) begin
                cipherText <= last_out;
                done       <= 1'b1;
                busy       <= 1'b0;
                round_cnt  <= 4'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_cipher_iter
//  Purpose  : Directed self-checking bench for aes_cipher_iter with Nk=4/6/8
//             using FIPS-197 vectors. Key schedules are expanded here from
//             an S-box derived arithmetically (GF inverse + affine map).
//             Honours CIPHER_KEY_LATCH_EN for the key-change scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_cipher_iter;

    logic clk;
    logic reset;

    logic         start_v [0:2];
    logic [0:127] pt_v    [0:2];
    logic         busy_v  [0:2];
    logic         done_v  [0:2];
    logic [0:127] ct_v    [0:2];

    logic [0:1407] keys4;
    logic [0:1663] keys6;
    logic [0:1919] keys8;

    int vectors;
    int miscompares;
    int overlap;

    logic [7:0] sbox_m [0:255];

    localparam logic [0:127] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:127] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_cipher_iter #(.Nk(4)) dut4 (
        .clks(clk), .reset(reset), .start(start_v[0]), .plainText(pt_v[0]),
        .keys(keys4), .busy(busy_v[0]), .done(done_v[0]), .cipherText(ct_v[0])
    );
    aes_cipher_iter #(.Nk(6)) dut6 (
        .clks(clk), .reset(reset), .start(start_v[1]), .plainText(pt_v[1]),
        .keys(keys6), .busy(busy_v[1]), .done(done_v[1]), .cipherText(ct_v[1])
    );
    aes_cipher_iter #(.Nk(8)) dut8 (
        .clks(clk), .reset(reset), .start(start_v[2]), .plainText(pt_v[2]),
        .keys(keys8), .busy(busy_v[2]), .done(done_v[2]), .cipherText(ct_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // Key expansion; key is left-aligned, result is words 0..4*(Nr+1)-1.
    task automatic expand(input int nk, input logic [0:255] key, output logic [0:1919] sched);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nwords;
        nwords = 4 * (nk + 7);
        rcon   = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < nwords; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        sched = '0;
        for (int i = 0; i < nwords; i++) sched[32*i +: 32] = w[i];
    endtask

    // ---------------- stimulus / check helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk128(input string tag, input logic [0:127] obs, input logic [0:127] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge and count edges (start edge included) until done.
    task automatic go(input int d, input bit scramble, output int n);
        start_v[d] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            start_v[d] = 1'b0;
            if (scramble) pt_v[d] = {$urandom, $urandom, $urandom, $urandom};
            if (busy_v[d] && done_v[d]) overlap++;
        end while (!done_v[d] && n < 60);
    endtask

    logic [0:1919] s4, s6, s8, sb;
    logic [0:127]  ct_a, ct_b;
    int            n, first_done, second_done;

    initial begin
        vectors     = 0;
        miscompares = 0;
        overlap     = 0;
        reset       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            pt_v[i]    = '0;
        end
        keys4 = '0;
        keys6 = '0;
        keys8 = '0;

        build_sbox();
        expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, s4);
        expand(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, s6);
        expand(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, s8);
        expand(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, sb);
        keys4 = s4[0:1407];
        keys6 = s6[0:1663];
        keys8 = s8;

        // Reset state
        step(); step(); step();
        chkint("reset busy4", int'(busy_v[0]), 0);
        chkint("reset done4", int'(done_v[0]), 0);
        chk128("reset ct4", ct_v[0], '0);
        chkint("reset busy8", int'(busy_v[2]), 0);
        reset = 1'b0;
        step();

        // AES-128 basic
        pt_v[0] = PT1;
        go(0, 1'b0, n);
        chkint("aes128 latency", n, 11);
        chk128("aes128 ct", ct_v[0], CT4);
        step();
        chkint("aes128 done one cycle", int'(done_v[0]), 0);
        chk128("aes128 ct hold", ct_v[0], CT4);

        // AES-192 / AES-256
        pt_v[1] = PT1;
        go(1, 1'b0, n);
        chkint("aes192 latency", n, 13);
        chk128("aes192 ct", ct_v[1], CT6);
        pt_v[2] = PT1;
        go(2, 1'b0, n);
        chkint("aes256 latency", n, 15);
        chk128("aes256 ct", ct_v[2], CT8);

        // start held high: mid-flight start ignored, back-to-back in done cycle
        step();
        pt_v[0]     = PT1;
        start_v[0]  = 1'b1;
        n           = 0;
        first_done  = 0;
        second_done = 0;
        ct_a        = '0;
        ct_b        = '0;
        while (second_done == 0 && n < 60) begin
            step();
            n++;
            if (n == 1) pt_v[0] = PTB;
            if (busy_v[0] && done_v[0]) overlap++;
            if (done_v[0]) begin
                if (first_done == 0) begin
                    first_done = n;
                    ct_a       = ct_v[0];
                    keys4      = sb[0:1407];
                end else begin
                    second_done = n;
                    ct_b        = ct_v[0];
                end
            end
        end
        start_v[0] = 1'b0;
        chkint("held start first done", first_done, 11);
        chk128("held start first ct", ct_a, CT4);
        chkint("held start second done", second_done, 22);
        chk128("held start second ct", ct_b, CTB);
        step();
        chkint("held start done drops", int'(done_v[0]), 0);
        keys4 = s4[0:1407];

        // Reset in round 5 discards the block
        pt_v[0]    = PT1;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        step(); step(); step(); step();
        chkint("pre-reset busy", int'(busy_v[0]), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chkint("mid reset busy", int'(busy_v[0]), 0);
        chkint("mid reset done", int'(done_v[0]), 0);
        chk128("mid reset ct", ct_v[0], '0);
        go(0, 1'b0, n);
        chkint("post reset latency", n, 11);
        chk128("post reset ct", ct_v[0], CT4);

        // Keys zeroed after t0
        step();
        pt_v[0]    = PT1;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        keys4      = '0;
        n          = 1;
        while (!done_v[0] && n < 60) begin
            step();
            n++;
        end
        chkint("key change latency", n, 11);
`ifdef CIPHER_KEY_LATCH_EN
        chk128("latched keys ct", ct_v[0], CT4);
`else
        vectors++;
        assert (ct_v[0] !== CT4) else begin
            miscompares++;
            $error("FAIL live keys ct: observed %h expected anything but %h", ct_v[0], CT4);
        end
`endif
        keys4 = s4[0:1407];

        // plainText scrambled every cycle after t0
        step();
        overlap = 0;
        pt_v[0] = PT1;
        go(0, 1'b1, n);
        chkint("scramble latency", n, 11);
        chk128("scramble ct", ct_v[0], CT4);
        chkint("busy with done overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
